wb_stage_gen: RTL and testbench
===============================

Name: wb_stage_gen

Overview:
Parametrised writeback stage, the successor to the current single-cycle WB stage. It sits after MEM and holds one instruction in a valid/allowin stage register. It adds the following:
- configurable data and register-address widths
- a CSR read latency of CSR_LAT cycles, during which the stage stalls
- a priority-encoded exception vector
- a retired-instruction counter

It drives the regfile write port, the CSR file, the flush and exception signals to the front end, and the trace debug port.

Parameters:
DW, 32, datapath width (regfile data, PC, CSR data, vaddr)
AW, 5, regfile address width
CSR_LAT, 0, extra cycles from csr_re assertion to csr_rvalue valid (0..15)
EENTRY_NUM, 14'h00c, CSR number read while an exception is signalled
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  MEM has an instruction for WB
wb_allowin  out  1  WB can accept this cycle
in_pc  in  DW  instruction PC
in_rf_we  in  1  regfile write request
in_rf_waddr  in  AW  destination register
in_rf_wdata  in  DW  result from MEM
in_csr_re / in_csr_we  in  1 / 1  CSR read / write request
in_csr_num  in  14  CSR number
in_csr_wmask / in_csr_wvalue  in  DW / DW  CSR write mask / value
in_ertn  in  1  ertn instruction
in_exc  in  6  {INT,ADEF,SYSCALL,BRK,INE,ALE} exception flags
in_esubcode  in  9  exception subcode
in_vaddr  in  DW  faulting virtual address
rf_we / rf_waddr / rf_wdata  out  1 / AW / DW  regfile write port, also the forwarding bus to ID
csr_re / csr_num  out  1 / 14  CSR read port
csr_rvalue  in  DW  CSR read data
csr_we / csr_wmask / csr_wvalue  out  1 / DW / DW  CSR write port
wb_ex  out  1  exception taken
wb_ecode  out  6  exception code
wb_esubcode  out  9  exception subcode
wb_ex_pc  out  DW  PC of the excepting instruction
wb_vaddr  out  DW  faulting virtual address
ertn_flush  out  1  ertn flush
retired_cnt  out  CNT_W  count of instructions retired without exception
debug_wb_pc  out  DW  trace PC
debug_wb_rf_we  out  DW/8  trace write enable, replicated
debug_wb_rf_wnum  out  AW  trace register number
debug_wb_rf_wdata  out  DW  trace write data

Behaviour:
- Reset (resetn low, asynchronous): all stage registers, wb_valid, lat_cnt and retired_cnt go to 0. With wb_valid=0 every enable output is 0: rf_we, csr_we, csr_re, wb_ex, ertn_flush and debug_wb_rf_we. Data outputs are 0. Reset asserted mid-stall abandons the instruction.
- exc_any = |in_exc latched. wb_ex = wb_valid & exc_any. ertn_flush = wb_valid & ertn & ~exc_any.
- Capture: on in_valid & wb_allowin & ~(wb_ex | ertn_flush), all fields are registered.
  - lat_cnt <= (in_csr_re & ~|in_exc) ? CSR_LAT : 0.
- wb_valid next state:
  - 0 if wb_ex | ertn_flush (flush wins over capture the same cycle)
  - else in_valid if wb_allowin
  - else hold
- Stall: ready_go = (lat_cnt == 0). wb_allowin = ~wb_valid | ready_go. While wb_valid & lat_cnt != 0, lat_cnt decrements by 1 each cycle. With CSR_LAT=0 the stage is single-cycle.
- Side effects occur only on the retire cycle (wb_valid & ready_go). These are rf_we, csr_we, ertn_flush, wb_ex and debug_wb_rf_we. A stalled instruction produces none.
- rf_we = retire & in_rf_we_q & ~exc_any. rf_wdata = csr_re_q ? csr_rvalue : wdata_q.
- csr_re = wb_valid & (csr_re_q | exc_any). csr_num = exc_any ? EENTRY_NUM : csr_num_q. csr_we = retire & csr_we_q & ~exc_any.
- wb_ecode priority, highest first: INT=0x0, ADEF=0x8, SYSCALL=0xb, BRK=0xc, INE=0xd, ALE=0x9. The value is 0 when exc_any=0. wb_ex_pc = pc_q.
- retired_cnt: +1 on each retire without exception, including ertn. It wraps modulo 2^CNT_W. It does not count excepting or flushed instructions.
- Debug outputs: debug_wb_rf_we = {DW/8{rf_we}}. debug_wb_pc = pc_q. debug_wb_rf_wnum = waddr_q. debug_wb_rf_wdata = rf_wdata.

Test Plan:
- Reset, then add.w r4 result 0x1234 with pc 0x1c000000 and CSR_LAT=0 -> next cycle rf_we=1, rf_waddr=4, rf_wdata=0x1234, debug_wb_rf_we=4'hf, retired_cnt=1.
- CSR_LAT=2: csrrd r5 (CRMD) with csr_rvalue=0x8 -> wb_allowin=0 for 2 cycles, no rf_we; on the 3rd cycle rf_we=1, rf_wdata=0x8, allowin=1.
- in_exc = INT|SYSCALL, pc 0x1c000040 -> wb_ecode=0x0, wb_ex=1, csr_num=0x00c, rf_we=0, retired_cnt unchanged. wb_valid=0 next cycle and a concurrent in_valid is dropped.
- ertn with in_valid held high -> ertn_flush=1 for one cycle, retired_cnt +1, the next instruction is not captured that cycle.
- Assert resetn low during a CSR_LAT=3 stall -> all outputs 0 immediately; after release wb_allowin=1 and retired_cnt=0.
- CNT_W=4: 16 retires -> retired_cnt wraps to 0.

Source files
------------

// File: rtl/wb_stage_gen.sv
// wb_stage_gen: parametrised writeback stage.
//
// Holds one instruction from MEM in a valid/allowin stage register and retires
// it into the regfile, the CSR file and the trace port. A CSR read holds the
// stage for CSR_LAT extra cycles until csr_rvalue is valid. An instruction that
// carries an exception or an ertn flushes the front end when it retires, and it
// blocks capture of the next instruction in that cycle.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid / wb_allowin  MEM -> WB handshake
//   in_*                   instruction payload from MEM
//   rf_we/rf_waddr/rf_wdata
//                          regfile write port, also the forwarding bus to ID
//   csr_re/csr_num/csr_rvalue
//                          CSR read port (EENTRY_NUM while an exception is shown)
//   csr_we/csr_wmask/csr_wvalue
//                          CSR write port
//   wb_ex/wb_ecode/wb_esubcode/wb_ex_pc/wb_vaddr
//                          exception report to the CSR file and front end
//   ertn_flush             exception-return flush
//   retired_cnt            instructions retired without exception (wraps)
//   debug_wb_*             trace port
module wb_stage_gen #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned CSR_LAT    = 0,
    parameter logic [13:0] EENTRY_NUM = 14'h00c,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             in_valid,
    output logic             wb_allowin,
    input  logic [DW-1:0]    in_pc,
    input  logic             in_rf_we,
    input  logic [AW-1:0]    in_rf_waddr,
    input  logic [DW-1:0]    in_rf_wdata,
    input  logic             in_csr_re,
    input  logic             in_csr_we,
    input  logic [13:0]      in_csr_num,
    input  logic [DW-1:0]    in_csr_wmask,
    input  logic [DW-1:0]    in_csr_wvalue,
    input  logic             in_ertn,
    input  logic [5:0]       in_exc,
    input  logic [8:0]       in_esubcode,
    input  logic [DW-1:0]    in_vaddr,

    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,

    output logic             csr_re,
    output logic [13:0]      csr_num,
    input  logic [DW-1:0]    csr_rvalue,
    output logic             csr_we,
    output logic [DW-1:0]    csr_wmask,
    output logic [DW-1:0]    csr_wvalue,

    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [DW-1:0]    wb_ex_pc,
    output logic [DW-1:0]    wb_vaddr,
    output logic             ertn_flush,

    output logic [CNT_W-1:0] retired_cnt,

    output logic [DW-1:0]    debug_wb_pc,
    output logic [DW/8-1:0]  debug_wb_rf_we,
    output logic [AW-1:0]    debug_wb_rf_wnum,
    output logic [DW-1:0]    debug_wb_rf_wdata
);

    localparam int unsigned LAT_W = 4;
    localparam int unsigned WE_W  = DW / 8;
    localparam int unsigned EXC_W = 6;

    // Bit positions inside in_exc = {INT, ADEF, SYSCALL, BRK, INE, ALE}
    localparam int unsigned EXC_INT  = 5;
    localparam int unsigned EXC_ADEF = 4;
    localparam int unsigned EXC_SYS  = 3;
    localparam int unsigned EXC_BRK  = 2;
    localparam int unsigned EXC_INE  = 1;
    localparam int unsigned EXC_ALE  = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    // Payload held by the stage register for the instruction in WB
    typedef struct packed {
        logic [DW-1:0]    pc;
        logic             rf_we;
        logic [AW-1:0]    rf_waddr;
        logic [DW-1:0]    rf_wdata;
        logic             csr_re;
        logic             csr_we;
        logic [13:0]      csr_num;
        logic [DW-1:0]    csr_wmask;
        logic [DW-1:0]    csr_wvalue;
        logic             ertn;
        logic [EXC_W-1:0] exc;
        logic [8:0]       esubcode;
        logic [DW-1:0]    vaddr;
    } wb_payload_t;

    wb_payload_t      stage_q;
    wb_payload_t      stage_in;
    logic             wb_valid;
    logic [LAT_W-1:0] lat_cnt;

    logic             exc_any;
    logic             ready_go;
    logic             retire;
    logic             flush;
    logic             capture;
    logic [LAT_W-1:0] lat_load;

    // Pack the incoming instruction
    always_comb begin
        stage_in            = '0;
        stage_in.pc         = in_pc;
        stage_in.rf_we      = in_rf_we;
        stage_in.rf_waddr   = in_rf_waddr;
        stage_in.rf_wdata   = in_rf_wdata;
        stage_in.csr_re     = in_csr_re;
        stage_in.csr_we     = in_csr_we;
        stage_in.csr_num    = in_csr_num;
        stage_in.csr_wmask  = in_csr_wmask;
        stage_in.csr_wvalue = in_csr_wvalue;
        stage_in.ertn       = in_ertn;
        stage_in.exc        = in_exc;
        stage_in.esubcode   = in_esubcode;
        stage_in.vaddr      = in_vaddr;
    end

    // Handshake and retire qualification
    assign exc_any    = |stage_q.exc;
    assign ready_go   = (lat_cnt == '0);
    assign wb_allowin = ~wb_valid | ready_go;
    assign retire     = wb_valid & ready_go;
    assign flush      = wb_ex | ertn_flush;
    assign capture    = in_valid & wb_allowin & ~flush;

    // An excepting instruction never waits for CSR data: it only reads EENTRY
    assign lat_load   = (in_csr_re & ~(|in_exc)) ? LAT_W'(CSR_LAT) : '0;

    // Stage payload register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_q <= '0;
        end else if (capture) begin
            stage_q <= stage_in;
        end
    end

    // Valid bit: a flush drops both the retiring and any offered instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid <= in_valid;
        end
    end

    // CSR read latency counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_cnt <= '0;
        end else if (capture) begin
            lat_cnt <= lat_load;
        end else if (wb_valid && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Retired-instruction counter, wraps at 2^CNT_W
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retired_cnt <= '0;
        end else if (retire && !exc_any) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // Regfile write port
    assign rf_we    = retire & stage_q.rf_we & ~exc_any;
    assign rf_waddr = stage_q.rf_waddr;
    assign rf_wdata = stage_q.csr_re ? csr_rvalue : stage_q.rf_wdata;

    // CSR ports; the read port fetches EENTRY while an exception is shown
    assign csr_re     = wb_valid & (stage_q.csr_re | exc_any);
    assign csr_num    = exc_any ? EENTRY_NUM : stage_q.csr_num;
    assign csr_we     = retire & stage_q.csr_we & ~exc_any;
    assign csr_wmask  = stage_q.csr_wmask;
    assign csr_wvalue = stage_q.csr_wvalue;

    // Exception and ertn reporting
    assign wb_ex       = retire & exc_any;
    assign ertn_flush  = retire & stage_q.ertn & ~exc_any;
    assign wb_esubcode = stage_q.esubcode;
    assign wb_ex_pc    = stage_q.pc;
    assign wb_vaddr    = stage_q.vaddr;

    // Exception code, highest-priority flag wins
    always_comb begin
        wb_ecode = 6'h00;
        if (stage_q.exc[EXC_INT]) begin
            wb_ecode = ECODE_INT;
        end else if (stage_q.exc[EXC_ADEF]) begin
            wb_ecode = ECODE_ADEF;
        end else if (stage_q.exc[EXC_SYS]) begin
            wb_ecode = ECODE_SYS;
        end else if (stage_q.exc[EXC_BRK]) begin
            wb_ecode = ECODE_BRK;
        end else if (stage_q.exc[EXC_INE]) begin
            wb_ecode = ECODE_INE;
        end else if (stage_q.exc[EXC_ALE]) begin
            wb_ecode = ECODE_ALE;
        end
    end

    // Trace port
    assign debug_wb_pc       = stage_q.pc;
    assign debug_wb_rf_we    = {WE_W{rf_we}};
    assign debug_wb_rf_wnum  = stage_q.rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_gen.sv
// tb_wb_stage_gen: three writeback stages (CSR_LAT 0/2/3, counter widths 4/32/32)
// share one stimulus stream; each is checked every cycle against a cycle-count
// model, and selected cycles are pinned with hand-computed literals.
module tb_wb_stage_gen;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic [5:0]  exc;
        logic [8:0]  esub;
        logic [31:0] vaddr;
    } ins_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    ins_t        cur = '0;
    logic [31:0] csr_rvalue = 32'd0;
    bit          chk_en = 1'b0;

    int n_vec = 0;
    int n_mis = 0;

    logic        o_allowin [3];
    logic        o_rf_we   [3];
    logic [4:0]  o_waddr   [3];
    logic [31:0] o_wdata   [3];
    logic        o_csr_re  [3];
    logic [13:0] o_csr_num [3];
    logic        o_csr_we  [3];
    logic [31:0] o_wmask   [3];
    logic [31:0] o_wvalue  [3];
    logic        o_ex      [3];
    logic [5:0]  o_ecode   [3];
    logic [8:0]  o_esub    [3];
    logic [31:0] o_ex_pc   [3];
    logic [31:0] o_vaddr   [3];
    logic        o_ertn    [3];
    logic [31:0] o_cnt     [3];
    logic [31:0] o_dpc     [3];
    logic [3:0]  o_dwe     [3];
    logic [4:0]  o_dwnum   [3];
    logic [31:0] o_dwdata  [3];

    always #5 clk = ~clk;

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    function automatic longint unsigned cnt_mask(input int i);
        return (i == 0) ? 64'hF : 64'hFFFF_FFFF;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L  = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        localparam int unsigned CW = (g == 0) ? 4 : 32;
        logic [CW-1:0] cnt;
        wb_stage_gen #(
            .DW(32), .AW(5), .CSR_LAT(L), .EENTRY_NUM(14'h00c), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .resetn(resetn),
            .in_valid(in_valid), .wb_allowin(o_allowin[g]),
            .in_pc(cur.pc), .in_rf_we(cur.rf_we), .in_rf_waddr(cur.waddr),
            .in_rf_wdata(cur.wdata), .in_csr_re(cur.csr_re), .in_csr_we(cur.csr_we),
            .in_csr_num(cur.csr_num), .in_csr_wmask(cur.wmask),
            .in_csr_wvalue(cur.wvalue), .in_ertn(cur.ertn), .in_exc(cur.exc),
            .in_esubcode(cur.esub), .in_vaddr(cur.vaddr),
            .rf_we(o_rf_we[g]), .rf_waddr(o_waddr[g]), .rf_wdata(o_wdata[g]),
            .csr_re(o_csr_re[g]), .csr_num(o_csr_num[g]), .csr_rvalue(csr_rvalue),
            .csr_we(o_csr_we[g]), .csr_wmask(o_wmask[g]), .csr_wvalue(o_wvalue[g]),
            .wb_ex(o_ex[g]), .wb_ecode(o_ecode[g]), .wb_esubcode(o_esub[g]),
            .wb_ex_pc(o_ex_pc[g]), .wb_vaddr(o_vaddr[g]), .ertn_flush(o_ertn[g]),
            .retired_cnt(cnt),
            .debug_wb_pc(o_dpc[g]), .debug_wb_rf_we(o_dwe[g]),
            .debug_wb_rf_wnum(o_dwnum[g]), .debug_wb_rf_wdata(o_dwdata[g])
        );
        assign o_cnt[g] = 32'(cnt);
    end

    // ---------------- model: instruction in WB, ready at a cycle number ----------
    int unsigned      cyc = 0;
    bit               m_v   [3];
    ins_t             m_f   [3];
    int unsigned      m_rdy [3];
    longint unsigned  m_cnt [3];

    function automatic logic [5:0] ecode_of(input logic [5:0] e);
        // {INT, ADEF, SYSCALL, BRK, INE, ALE} scanned from highest priority
        logic [5:0] codes [6];
        codes = '{6'h00, 6'h08, 6'h0b, 6'h0c, 6'h0d, 6'h09};
        for (int k = 0; k < 6; k++) begin
            if (e[5-k]) return codes[k];
        end
        return 6'h00;
    endfunction

    task automatic model_step(input int i);
        bit busy = m_v[i] && (cyc < m_rdy[i]);
        bit ret  = m_v[i] && !busy;
        bit exc  = (m_f[i].exc != 6'd0);
        bit fl   = (m_v[i] && exc) || (ret && m_f[i].ertn && !exc);
        bit cap  = in_valid && !busy && !fl;
        if (ret && !exc) m_cnt[i] = (m_cnt[i] + 1) & cnt_mask(i);
        if (fl) m_v[i] = 1'b0;
        else if (!busy) m_v[i] = in_valid;
        if (cap) begin
            m_f[i]   = cur;
            m_rdy[i] = cyc + 1 + ((cur.csr_re && cur.exc == 6'd0) ? lat_of(i) : 0);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc = 0;
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 1'b0; m_f[i] = '0; m_rdy[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
            cyc = cyc + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i);
        ins_t        f    = m_f[i];
        bit          ret  = m_v[i] && (cyc >= m_rdy[i]);
        bit          alw  = !m_v[i] || (cyc >= m_rdy[i]);
        bit          exc  = (f.exc != 6'd0);
        bit          e_we = ret && f.rf_we && !exc;
        logic [31:0] e_wd = f.csr_re ? csr_rvalue : f.wdata;
        string       p    = $sformatf("m%0d.", i);
        check({p, "wb_allowin"}, 64'(o_allowin[i]), 64'(alw));
        check({p, "rf_we"},      64'(o_rf_we[i]),   64'(e_we));
        check({p, "rf_waddr"},   64'(o_waddr[i]),   64'(f.waddr));
        check({p, "rf_wdata"},   64'(o_wdata[i]),   64'(e_wd));
        check({p, "csr_re"},     64'(o_csr_re[i]),  64'(m_v[i] && (f.csr_re || exc)));
        check({p, "csr_num"},    64'(o_csr_num[i]), 64'(exc ? 14'h00c : f.csr_num));
        check({p, "csr_we"},     64'(o_csr_we[i]),  64'(ret && f.csr_we && !exc));
        check({p, "csr_wmask"},  64'(o_wmask[i]),   64'(f.wmask));
        check({p, "csr_wvalue"}, 64'(o_wvalue[i]),  64'(f.wvalue));
        check({p, "wb_ex"},      64'(o_ex[i]),      64'(m_v[i] && exc));
        check({p, "wb_ecode"},   64'(o_ecode[i]),   64'(ecode_of(f.exc)));
        check({p, "wb_esubcode"},64'(o_esub[i]),    64'(f.esub));
        check({p, "wb_ex_pc"},   64'(o_ex_pc[i]),   64'(f.pc));
        check({p, "wb_vaddr"},   64'(o_vaddr[i]),   64'(f.vaddr));
        check({p, "ertn_flush"}, 64'(o_ertn[i]),    64'(ret && f.ertn && !exc));
        check({p, "retired_cnt"},64'(o_cnt[i]),     m_cnt[i]);
        check({p, "dbg_pc"},     64'(o_dpc[i]),     64'(f.pc));
        check({p, "dbg_we"},     64'(o_dwe[i]),     64'({4{e_we}}));
        check({p, "dbg_wnum"},   64'(o_dwnum[i]),   64'(f.waddr));
        check({p, "dbg_wdata"},  64'(o_dwdata[i]),  64'(e_wd));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) compare_inst(i);
        end
    end

    // ---------------- stimulus ----------------
    function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        ins_t x = '0;
        x.pc = pc; x.rf_we = 1'b1; x.waddr = rd; x.wdata = d;
        return x;
    endfunction

    function automatic ins_t csrrd(input logic [31:0] pc, input logic [4:0] rd, input logic [13:0] num);
        ins_t x = '0;
        x.pc = pc; x.rf_we = 1'b1; x.waddr = rd; x.csr_re = 1'b1; x.csr_num = num;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        ins_t x;
        ins_t tbl [8];

        // Reset state
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst.allowin", 64'(o_allowin[0]), 64'd1);
        check("rst.rf_we",   64'(o_rf_we[0]),   64'd0);
        check("rst.dbg_we",  64'(o_dwe[2]),     64'd0);
        check("rst.cnt",     64'(o_cnt[1]),     64'd0);
        tick();
        resetn = 1'b1;

        // add.w r4 = 0x1234, single cycle on the CSR_LAT=0 stage
        cur = alu(32'h1c00_0000, 5'd4, 32'h1234); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("add.rf_we",    64'(o_rf_we[0]),  64'd1);
        check("add.rf_waddr", 64'(o_waddr[0]),  64'd4);
        check("add.rf_wdata", 64'(o_wdata[0]),  64'h1234);
        check("add.dbg_we",   64'(o_dwe[0]),    64'hf);
        check("add.dbg_pc",   64'(o_dpc[0]),    64'h1c00_0000);
        tick();
        @(negedge clk);
        check("add.cnt", 64'(o_cnt[0]), 64'd1);
        drain(3);

        // csrrd r5 CRMD, two stall cycles on the CSR_LAT=2 stage
        csr_rvalue = 32'h8;
        cur = csrrd(32'h1c00_0004, 5'd5, 14'h0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("csr.l0_rf_we",   64'(o_rf_we[0]),   64'd1);
        check("csr.l0_wdata",   64'(o_wdata[0]),   64'h8);
        check("csr.stall1_alw", 64'(o_allowin[1]), 64'd0);
        check("csr.stall1_we",  64'(o_rf_we[1]),   64'd0);
        tick();
        @(negedge clk);
        check("csr.stall2_alw", 64'(o_allowin[1]), 64'd0);
        check("csr.stall2_we",  64'(o_rf_we[1]),   64'd0);
        tick();
        @(negedge clk);
        check("csr.ret_we",    64'(o_rf_we[1]),   64'd1);
        check("csr.ret_wdata", 64'(o_wdata[1]),   64'h8);
        check("csr.ret_waddr", 64'(o_waddr[1]),   64'd5);
        check("csr.ret_alw",   64'(o_allowin[1]), 64'd1);
        drain(4);

        // INT|SYSCALL exception with a following instruction offered at once
        x = alu(32'h1c00_0040, 5'd7, 32'hdead); x.exc = 6'b101000;
        cur = x; in_valid = 1'b1;
        tick();
        cur = alu(32'h1c00_0044, 5'd9, 32'h99);
        @(negedge clk);
        check("exc.wb_ex",   64'(o_ex[0]),      64'd1);
        check("exc.ecode",   64'(o_ecode[0]),   64'h0);
        check("exc.csr_num", 64'(o_csr_num[0]), 64'h00c);
        check("exc.rf_we",   64'(o_rf_we[0]),   64'd0);
        check("exc.ex_pc",   64'(o_ex_pc[0]),   64'h1c00_0040);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("exc.drop_we", 64'(o_rf_we[0]), 64'd0);
        check("exc.drop_ex", 64'(o_ex[0]),    64'd0);
        check("exc.cnt",     64'(o_cnt[0]),   64'd2);
        drain(4);

        // ertn with in_valid held high
        x = '0; x.pc = 32'h1c00_0080; x.ertn = 1'b1;
        cur = x; in_valid = 1'b1;
        tick();
        cur = alu(32'h1c00_0084, 5'd8, 32'h88);
        @(negedge clk);
        check("ertn.flush", 64'(o_ertn[0]), 64'd1);
        tick();
        @(negedge clk);
        check("ertn.flush_off", 64'(o_ertn[0]),  64'd0);
        check("ertn.no_cap",    64'(o_rf_we[0]), 64'd0);
        check("ertn.cnt",       64'(o_cnt[0]),   64'd3);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("ertn.next_we",    64'(o_rf_we[0]), 64'd1);
        check("ertn.next_wdata", 64'(o_wdata[0]), 64'h88);
        drain(4);

        // Reset in the middle of a CSR_LAT=3 stall
        csr_rvalue = 32'h55;
        cur = csrrd(32'h1c00_00c0, 5'd9, 14'h1); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("rstall.alw", 64'(o_allowin[2]), 64'd0);
        tick();
        resetn = 1'b0;
        #1;
        check("rstall.rf_we",  64'(o_rf_we[2]),   64'd0);
        check("rstall.csr_re", 64'(o_csr_re[2]),  64'd0);
        check("rstall.wdata",  64'(o_wdata[2]),   64'd0);
        check("rstall.alw0",   64'(o_allowin[2]), 64'd1);
        check("rstall.cnt0",   64'(o_cnt[0]),     64'd0);
        tick(); tick();
        resetn = 1'b1;
        @(negedge clk);
        check("rstall.alw1", 64'(o_allowin[2]), 64'd1);
        check("rstall.cnt1", 64'(o_cnt[2]),     64'd0);

        // 16 back-to-back retires: the 4-bit counter wraps
        tick();
        for (int i = 0; i < 16; i++) begin
            cur = alu(32'h1c00_1000 + 32'(i * 4), 5'(i + 1), 32'h100 + 32'(i));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap.cnt15", 64'(o_cnt[0]), 64'd15);
        tick();
        @(negedge clk);
        check("wrap.cnt0",  64'(o_cnt[0]), 64'd0);
        check("wrap.cnt16", 64'(o_cnt[1]), 64'd16);

        // Mixed stream, one vector per cycle regardless of backpressure
        tbl[0] = csrrd(32'h1c00_2000, 5'd3, 14'h6);
        tbl[0].csr_we = 1'b1; tbl[0].wmask = 32'hffff_ffff; tbl[0].wvalue = 32'h1c00_8000;
        tbl[1] = alu(32'h1c00_2004, 5'd10, 32'ha5a5_0001);
        tbl[2] = alu(32'h1c00_2008, 5'd11, 32'h0);
        tbl[2].exc = 6'b000001; tbl[2].vaddr = 32'h1c00_1003;
        tbl[3] = alu(32'h1c00_200c, 5'd12, 32'h0); tbl[3].exc = 6'b000110;
        tbl[4] = alu(32'h1c00_2010, 5'd13, 32'h0); tbl[4].exc = 6'b010001;
        tbl[4].esub = 9'h1; tbl[4].vaddr = 32'h1c00_2011;
        tbl[5] = csrrd(32'h1c00_2014, 5'd14, 14'h4);
        tbl[5].csr_we = 1'b1; tbl[5].wmask = 32'h0000_ff00; tbl[5].wvalue = 32'h1234_5678;
        tbl[6] = csrrd(32'h1c00_2018, 5'd15, 14'h5); tbl[6].exc = 6'b000010;
        tbl[7] = alu(32'h1c00_201c, 5'd16, 32'h7777);
        for (int i = 0; i < 8; i++) begin
            cur = tbl[i]; in_valid = 1'b1;
            csr_rvalue = 32'hc0de_0000 + 32'(i);
            tick();
        end
        drain(8);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
